// File: rtl/vga_pattern_timing.sv
// vga_pattern_timing
//   VGA timing generator with a built-in test-pattern source. A stage-0 pixel
//   counter (h_cnt_q / v_cnt_q) drives sync decode and pattern generation. A
//   single stage-1 register bank then presents sync, coordinates, the
//   frame-start strobe and RGB together, one cycle after stage 0. Because of
//   that, every output describes the same pixel.
//
// Ports
//   clk          pixel clock
//   clr_n        asynchronous active-low reset
//   en           pixel advance enable; all registers hold while low
//   mode         pattern select: 0 solid, 1 colour bars, 2 checker, 3 border
//   fg_rgb       foreground colour {R,G,B}, used by solid and checker modes
//   hsync/vsync  sync outputs, polarity set by HS_POL / VS_POL
//   vidon        high while the presented pixel is in the active area
//   hc/vc        column / line of the presented pixel
//   frame_start  high while pixel (0,0) is presented
//   red/green/blue  colour channels, zero outside the active area
module vga_pattern_timing #(
  parameter int   H_ACTIVE = 1024,
  parameter int   H_FP     = 24,
  parameter int   H_SYNC   = 136,
  parameter int   H_BP     = 160,
  parameter int   V_ACTIVE = 768,
  parameter int   V_FP     = 3,
  parameter int   V_SYNC   = 6,
  parameter int   V_BP     = 29,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   CW       = 4,
  parameter int   CNT_W    = 11,
  parameter int   CHK_LOG2 = 5
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic [3*CW-1:0]   fg_rgb,
  output logic              hsync,
  output logic              vsync,
  output logic              vidon,
  output logic [CNT_W-1:0]  hc,
  output logic [CNT_W-1:0]  vc,
  output logic              frame_start,
  output logic [CW-1:0]     red,
  output logic [CW-1:0]     green,
  output logic [CW-1:0]     blue
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int BAR_W   = H_ACTIVE / 8;

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT      = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT      = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] H_ACT_LAST = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] V_ACT_LAST = CNT_W'(V_ACTIVE - 1);
  localparam logic [CNT_W-1:0] HS_START   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END     = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END     = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] BAR_DIV    = CNT_W'(BAR_W);

  // stage 0
  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
  logic [1:0]       mode_q, mode_d;

  // stage 1
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             vidon_q, vidon_d;
  logic [CNT_W-1:0] hc_q, vc_q;
  logic             frame_start_q, frame_start_d;
  logic [3*CW-1:0]  rgb_q, rgb_d;

  logic       h_wrap, v_wrap, at_origin, active, on_border;
  logic [1:0] mode_eff;
  logic [2:0] bar_idx;

  assign h_wrap    = (h_cnt_q == H_LAST);
  assign v_wrap    = (v_cnt_q == V_LAST);
  assign at_origin = (h_cnt_q == '0) && (v_cnt_q == '0);
  assign active    = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);

  assign h_cnt_d = h_wrap ? '0 : h_cnt_q + 1'b1;
  assign v_cnt_d = h_wrap ? (v_wrap ? '0 : v_cnt_q + 1'b1) : v_cnt_q;

  // The mode sampled at the origin is used for pixel (0,0) as well, so a
  // whole frame is always rendered in one mode.
  assign mode_d   = at_origin ? mode : mode_q;
  assign mode_eff = mode_d;

  assign bar_idx   = 3'(h_cnt_q / BAR_DIV);
  assign on_border = (h_cnt_q == '0) || (h_cnt_q == H_ACT_LAST) ||
                     (v_cnt_q == '0) || (v_cnt_q == V_ACT_LAST);

  assign hsync_d = ((h_cnt_q >= HS_START) && (h_cnt_q < HS_END)) ? HS_POL : ~HS_POL;
  assign vsync_d = ((v_cnt_q >= VS_START) && (v_cnt_q < VS_END)) ? VS_POL : ~VS_POL;
  assign vidon_d = active;
  assign frame_start_d = at_origin;

  always_comb begin
    rgb_d = '0;
    if (active) begin
      case (mode_eff)
        2'd0: rgb_d = fg_rgb;
        2'd1: rgb_d = {{CW{~bar_idx[1]}}, {CW{~bar_idx[2]}}, {CW{~bar_idx[0]}}};
        2'd2: if (!(h_cnt_q[CHK_LOG2] ^ v_cnt_q[CHK_LOG2])) rgb_d = fg_rgb;
        default: if (on_border) rgb_d = '1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      mode_q        <= 2'd0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      vidon_q       <= 1'b0;
      hc_q          <= '0;
      vc_q          <= '0;
      frame_start_q <= 1'b0;
      rgb_q         <= '0;
    end else if (en) begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      mode_q        <= mode_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      vidon_q       <= vidon_d;
      hc_q          <= h_cnt_q;
      vc_q          <= v_cnt_q;
      frame_start_q <= frame_start_d;
      rgb_q         <= rgb_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign vidon       = vidon_q;
  assign hc          = hc_q;
  assign vc          = vc_q;
  assign frame_start = frame_start_q;
  assign red         = rgb_q[3*CW-1:2*CW];
  assign green       = rgb_q[2*CW-1:CW];
  assign blue        = rgb_q[CW-1:0];

endmodule

// File: tb/tb_vga_pattern_timing.sv
module tb_vga_pattern_timing;
  localparam int CW    = 4;
  localparam int CNT_W = 5;

  logic             clk, clr_n, en;
  logic [1:0]       mode;
  logic [3*CW-1:0]  fg_rgb;
  logic             hsync, vsync, vidon, frame_start;
  logic [CNT_W-1:0] hc, vc;
  logic [CW-1:0]    red, green, blue;
  logic [11:0]      rgb;

  int checks = 0;
  int failures = 0;

  assign rgb = {red, green, blue};

  vga_pattern_timing #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
    .V_ACTIVE(8),  .V_FP(1), .V_SYNC(2), .V_BP(3),
    .HS_POL(1'b0), .VS_POL(1'b0),
    .CW(CW), .CNT_W(CNT_W), .CHK_LOG2(1)
  ) dut (
    .clk(clk), .clr_n(clr_n), .en(en), .mode(mode), .fg_rgb(fg_rgb),
    .hsync(hsync), .vsync(vsync), .vidon(vidon), .hc(hc), .vc(vc),
    .frame_start(frame_start), .red(red), .green(green), .blue(blue)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    clr_n = 1'b0; en = 1'b0; mode = 2'd0; fg_rgb = 12'hF80;
    #12;
    checks++; if (hsync !== 1'b1) begin failures++; $display("FAIL rst_hsync got=%b exp=1", hsync); end
    checks++; if (vsync !== 1'b1) begin failures++; $display("FAIL rst_vsync got=%b exp=1", vsync); end
    checks++; if (vidon !== 1'b0) begin failures++; $display("FAIL rst_vidon got=%b exp=0", vidon); end
    checks++; if (hc !== 5'd0 || vc !== 5'd0) begin failures++; $display("FAIL rst_pos got=%0d,%0d exp=0,0", hc, vc); end
    checks++; if (frame_start !== 1'b0) begin failures++; $display("FAIL rst_fs got=%b exp=0", frame_start); end
    checks++; if (rgb !== 12'h000) begin failures++; $display("FAIL rst_rgb got=%h exp=000", rgb); end
  endtask

  // Line 0 in solid mode: 16 active pixels of F80, hsync low for hc 18..20.
  task automatic test_line;
    clr_n = 1'b1; en = 1'b1;
    for (int i = 0; i < 25; i++) begin
      step;
      checks++; if (hc !== 5'(i) || vc !== 5'd0) begin failures++; $display("FAIL line_pos i=%0d got=%0d,%0d", i, hc, vc); end
      checks++; if (vidon !== (i < 16)) begin failures++; $display("FAIL line_vidon i=%0d got=%b exp=%b", i, vidon, (i < 16)); end
      checks++; if (rgb !== ((i < 16) ? 12'hF80 : 12'h000)) begin failures++; $display("FAIL line_rgb i=%0d got=%h", i, rgb); end
      checks++; if (hsync !== !(i >= 18 && i <= 20)) begin failures++; $display("FAIL line_hsync i=%0d got=%b", i, hsync); end
      checks++; if (frame_start !== (i == 0)) begin failures++; $display("FAIL line_fs i=%0d got=%b exp=%b", i, frame_start, (i == 0)); end
    end
  endtask

  // Lines 1..13 of the first frame.
  task automatic test_frame;
    int vs_low, vs_bad, vid_cnt, vid_bad, fs_cnt, blank_bad;
    vs_low = 0; vs_bad = 0; vid_cnt = 0; vid_bad = 0; fs_cnt = 0; blank_bad = 0;
    for (int i = 25; i < 350; i++) begin
      step;
      checks++; if (hc !== 5'(i % 25) || vc !== 5'(i / 25)) begin failures++; $display("FAIL frame_pos i=%0d got=%0d,%0d exp=%0d,%0d", i, hc, vc, i % 25, i / 25); end
      if (vsync === 1'b0) begin
        vs_low++;
        if (!(vc == 5'd9 || vc == 5'd10)) vs_bad++;
      end
      if (vidon === 1'b1) begin
        vid_cnt++;
        if (vc >= 5'd8) vid_bad++;
      end else if (rgb !== 12'h000) blank_bad++;
      if (frame_start === 1'b1) fs_cnt++;
    end
    checks++; if (vs_low !== 50) begin failures++; $display("FAIL frame_vsync_len got=%0d exp=50", vs_low); end
    checks++; if (vs_bad !== 0) begin failures++; $display("FAIL frame_vsync_lines got=%0d exp=0", vs_bad); end
    checks++; if (vid_cnt !== 112) begin failures++; $display("FAIL frame_vidon_cnt got=%0d exp=112", vid_cnt); end
    checks++; if (vid_bad !== 0) begin failures++; $display("FAIL frame_vidon_late got=%0d exp=0", vid_bad); end
    checks++; if (blank_bad !== 0) begin failures++; $display("FAIL frame_blank_rgb got=%0d exp=0", blank_bad); end
    checks++; if (fs_cnt !== 0) begin failures++; $display("FAIL frame_fs_extra got=%0d exp=0", fs_cnt); end
  endtask

  task automatic test_bars;
    logic [11:0] bars [8];
    bars = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
    mode = 2'd1;
    for (int i = 0; i < 16; i++) begin
      step;
      if (i == 0) begin
        checks++; if (frame_start !== 1'b1 || hc !== 5'd0 || vc !== 5'd0) begin failures++; $display("FAIL bars_fs350 got fs=%b pos=%0d,%0d exp 1 0,0", frame_start, hc, vc); end
      end
      checks++; if (rgb !== bars[i / 2]) begin failures++; $display("FAIL bars_rgb hc=%0d got=%h exp=%h", i, rgb, bars[i / 2]); end
    end
  endtask

  task automatic test_mode_switch;
    bit found;
    int solid_bad;
    mode = 2'd0;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      step;
      if (frame_start === 1'b1) found = 1'b1;
    end
    checks++; if (!found) begin failures++; $display("FAIL sw_frame1 got=timeout exp=frame_start"); end
    checks++; if (rgb !== 12'hF80) begin failures++; $display("FAIL sw_solid00 got=%h exp=F80", rgb); end
    repeat (75) step;
    checks++; if (hc !== 5'd0 || vc !== 5'd3) begin failures++; $display("FAIL sw_pos got=%0d,%0d exp=0,3", hc, vc); end
    mode = 2'd2;
    found = 1'b0; solid_bad = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      step;
      if (frame_start === 1'b1) found = 1'b1;
      else if (vidon === 1'b1 && rgb !== 12'hF80) solid_bad++;
    end
    checks++; if (!found) begin failures++; $display("FAIL sw_frame2 got=timeout exp=frame_start"); end
    checks++; if (solid_bad !== 0) begin failures++; $display("FAIL sw_rest_solid got=%0d bad exp=0", solid_bad); end
    checks++; if (rgb !== 12'hF80) begin failures++; $display("FAIL sw_chk00 got=%h exp=F80", rgb); end
  endtask

  // Presenting pixel (0,0) of a checker frame; pause, then resume.
  task automatic test_en_hold;
    en = 1'b0;
    step; step;
    checks++; if (frame_start !== 1'b1) begin failures++; $display("FAIL hold_fs got=%b exp=1", frame_start); end
    checks++; if (hc !== 5'd0 || vc !== 5'd0) begin failures++; $display("FAIL hold_pos got=%0d,%0d exp=0,0", hc, vc); end
    checks++; if (rgb !== 12'hF80 || vidon !== 1'b1) begin failures++; $display("FAIL hold_rgb got=%h/%b exp=F80/1", rgb, vidon); end
    en = 1'b1;
    step;
    checks++; if (hc !== 5'd1 || frame_start !== 1'b0) begin failures++; $display("FAIL resume_pos got hc=%0d fs=%b exp 1 0", hc, frame_start); end
    checks++; if (rgb !== 12'hF80) begin failures++; $display("FAIL resume_chk10 got=%h exp=F80", rgb); end
    step;
    checks++; if (hc !== 5'd2 || rgb !== 12'h000) begin failures++; $display("FAIL chk20 got hc=%0d rgb=%h exp 2 000", hc, rgb); end
  endtask

  task automatic test_reset_mid;
    repeat (130) step;
    checks++; if (hc !== 5'd7 || vc !== 5'd5 || vidon !== 1'b1) begin failures++; $display("FAIL mid_pos got=%0d,%0d vid=%b exp=7,5 1", hc, vc, vidon); end
    #2 clr_n = 1'b0;
    #1;
    checks++; if (hc !== 5'd0 || vc !== 5'd0) begin failures++; $display("FAIL async_pos got=%0d,%0d exp=0,0", hc, vc); end
    checks++; if (vidon !== 1'b0 || frame_start !== 1'b0 || rgb !== 12'h000) begin failures++; $display("FAIL async_out got vid=%b fs=%b rgb=%h exp 0 0 000", vidon, frame_start, rgb); end
    checks++; if (hsync !== 1'b1 || vsync !== 1'b1) begin failures++; $display("FAIL async_sync got=%b%b exp=11", hsync, vsync); end
    @(posedge clk);
    #2 clr_n = 1'b1;
    step;
    checks++; if (hc !== 5'd0 || vc !== 5'd0 || frame_start !== 1'b1) begin failures++; $display("FAIL rel_first got=%0d,%0d fs=%b exp=0,0 1", hc, vc, frame_start); end
    checks++; if (vidon !== 1'b1 || rgb !== 12'hF80) begin failures++; $display("FAIL rel_pix got vid=%b rgb=%h exp 1 F80", vidon, rgb); end
    step;
    checks++; if (hc !== 5'd1 || frame_start !== 1'b0) begin failures++; $display("FAIL rel_next got hc=%0d fs=%b exp 1 0", hc, frame_start); end
  endtask

  initial begin
    test_reset;
    test_line;
    test_frame;
    test_bars;
    test_mode_switch;
    test_en_hold;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
